ibex_rf_wb_queue: RTL and testbench

IBEX_RF_WB_QUEUE -- requirements
Module: ibex_rf_wb_queue

---
 rtl/ibex_rf_pkg.sv | 18 +
 rtl/ibex_rf_wb_fifo.sv | 73 +++++++
 rtl/ibex_rf_wb_queue.sv | 94 +++++++++
 tb/tb_ibex_rf_wb_queue.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ibex_rf_pkg.sv
// Shared types and constants for the register-file write-back queue.
package ibex_rf_pkg;

  localparam int unsigned RF_WB_DEPTH      = 2;
  localparam int unsigned RF_WB_DATA_WIDTH = 32;

  typedef struct packed {
    logic [4:0]                  waddr;
    logic [RF_WB_DATA_WIDTH-1:0] wdata;
  } wb_entry_t;

  // A write is worth queueing only if it targets a real register:
  // x0 is hardwired, and x16..x31 do not exist in RV32E.
  function automatic logic wb_enqueuable(input logic [4:0] waddr, input bit rv32e);
    return (waddr != 5'd0) && !(rv32e && waddr[4]);
  endfunction

endpackage

// File: rtl/ibex_rf_wb_fifo.sv
// In-order write-back FIFO with two ordered push ports and one pop port.
module ibex_rf_wb_fifo
  import ibex_rf_pkg::*;
#(
  parameter type         entry_t = wb_entry_t,
  parameter int unsigned Depth   = RF_WB_DEPTH,
  localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW   = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push0_i,
  input  entry_t          push0_data_i,
  input  logic            push1_i,
  input  entry_t          push1_data_i,
  input  logic            pop_i,
  output logic [CntW-1:0] count_o,
  output entry_t          head_o,
  output entry_t          entries_o [Depth],
  output logic [Depth-1:0] valid_o
);

  entry_t          mem_q [Depth];
  logic [PtrW-1:0] rptr_q;
  logic [PtrW-1:0] wptr_q;
  logic [PtrW-1:0] wptr_inc;
  logic [CntW-1:0] count_q;
  logic            pop_en;

  // Pointer advance modulo Depth; n never exceeds 2 and Depth >= 2,
  // so one conditional subtraction is enough.
  function automatic logic [PtrW-1:0] ptr_add(input logic [PtrW-1:0] p, input int unsigned n);
    int unsigned s;
    s = 32'(p) + n;
    if (s >= Depth) s = s - Depth;
    return PtrW'(s);
  endfunction

  assign pop_en   = pop_i && (count_q != '0);
  assign wptr_inc = ptr_add(wptr_q, 1);

  // Storage write; push1 lands behind push0 when both fire.
  always_ff @(posedge clk_i) begin
    if (push0_i) mem_q[wptr_q] <= push0_data_i;
    if (push1_i) mem_q[push0_i ? wptr_inc : wptr_q] <= push1_data_i;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= ptr_add(rptr_q, 32'(pop_en));
      wptr_q  <= ptr_add(wptr_q, 32'(push0_i) + 32'(push1_i));
      count_q <= count_q + CntW'(push0_i) + CntW'(push1_i) - CntW'(pop_en);
    end
  end

  // Slot i is live when its distance from the read pointer is below count.
  always_comb begin
    valid_o = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      valid_o[i] = (((i + Depth - 32'(rptr_q)) % Depth) < 32'(count_q));
    end
  end

  assign entries_o = mem_q;
  assign head_o    = mem_q[rptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/ibex_rf_wb_queue.sv
// Register-file write-back queue: arbitrates LSU/EX writes, filters
// non-existent destinations and flags reads that hit a queued write.
module ibex_rf_wb_queue
  import ibex_rf_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = RF_WB_DEPTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,
  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 lsu_ready_o,
  output logic [4:0]           waddr_a_o,
  output logic [DataWidth-1:0] wdata_a_o,
  output logic                 we_a_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 pending_a_o,
  output logic                 pending_b_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef struct packed {
    logic [4:0]           waddr;
    logic [DataWidth-1:0] wdata;
  } entry_t;

  logic [CntW-1:0]  count;
  logic [CntW:0]    free;
  logic             lsu_ok;
  logic             ex_ok;
  logic             lsu_push;
  logic             ex_push;
  entry_t           lsu_entry;
  entry_t           ex_entry;
  entry_t           head;
  entry_t           entries [Depth];
  logic [Depth-1:0] valid;

  assign lsu_ok = wb_enqueuable(lsu_waddr_i, RV32E);
  assign ex_ok  = wb_enqueuable(ex_waddr_i, RV32E);

  // The head always retires this cycle, so its slot counts as free.
  assign free = (CntW+1)'(Depth) - {1'b0, count} + {{CntW{1'b0}}, count != '0};

  assign lsu_ready_o = free >= (CntW+1)'(1);
  assign ex_ready_o  = free >= ((CntW+1)'(1) + (CntW+1)'(lsu_valid_i && lsu_ok));

  assign lsu_push  = lsu_valid_i && lsu_ready_o && lsu_ok;
  assign ex_push   = ex_valid_i && ex_ready_o && ex_ok;
  assign lsu_entry = '{waddr: lsu_waddr_i, wdata: lsu_wdata_i};
  assign ex_entry  = '{waddr: ex_waddr_i, wdata: ex_wdata_i};

  // LSU goes on push port 0 because it is the older instruction.
  ibex_rf_wb_fifo #(
    .entry_t (entry_t),
    .Depth   (Depth)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push0_i      (lsu_push),
    .push0_data_i (lsu_entry),
    .push1_i      (ex_push),
    .push1_data_i (ex_entry),
    .pop_i        (we_a_o),
    .count_o      (count),
    .head_o       (head),
    .entries_o    (entries),
    .valid_o      (valid)
  );

  assign we_a_o    = (count != '0);
  assign waddr_a_o = we_a_o ? head.waddr : '0;
  assign wdata_a_o = we_a_o ? head.wdata : '0;

  // Read-after-write hazard detection against every live queue slot.
  always_comb begin
    pending_a_o = 1'b0;
    pending_b_o = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (valid[i] && (raddr_a_i != '0) && (entries[i].waddr == raddr_a_i)) pending_a_o = 1'b1;
      if (valid[i] && (raddr_b_i != '0) && (entries[i].waddr == raddr_b_i)) pending_b_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_ibex_rf_wb_queue.sv
// Self-checking bench for ibex_rf_wb_queue (RV32I and RV32E instances).
module tb_ibex_rf_wb_queue;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ex_valid_i, lsu_valid_i;
  logic [4:0]  ex_waddr_i, lsu_waddr_i, raddr_a_i, raddr_b_i;
  logic [31:0] ex_wdata_i, lsu_wdata_i;

  logic        ex_ready_o, lsu_ready_o, we_a_o, pending_a_o, pending_b_o;
  logic [4:0]  waddr_a_o;
  logic [31:0] wdata_a_o;

  logic        ex_ready_e, lsu_ready_e, we_a_e, pending_a_e, pending_b_e;
  logic [4:0]  waddr_a_e;
  logic [31:0] wdata_a_e;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  always #5 clk_i = ~clk_i;

  ibex_rf_wb_queue #(.RV32E(1'b0), .DataWidth(32), .Depth(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i), .ex_ready_o(ex_ready_o),
    .lsu_valid_i(lsu_valid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_ready_o(lsu_ready_o),
    .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o), .we_a_o(we_a_o),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .pending_a_o(pending_a_o), .pending_b_o(pending_b_o)
  );

  ibex_rf_wb_queue #(.RV32E(1'b1), .DataWidth(32), .Depth(2)) dut_e (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i), .ex_ready_o(ex_ready_e),
    .lsu_valid_i(lsu_valid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_ready_o(lsu_ready_e),
    .waddr_a_o(waddr_a_e), .wdata_a_o(wdata_a_e), .we_a_o(we_a_e),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .pending_a_o(pending_a_e), .pending_b_o(pending_b_e)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    ex_valid_i  = 1'b0; ex_waddr_i  = '0; ex_wdata_i  = '0;
    lsu_valid_i = 1'b0; lsu_waddr_i = '0; lsu_wdata_i = '0;
  endtask

  task automatic test_reset();
    idle();
    raddr_a_i = 5'd5; raddr_b_i = 5'd3;
    rst_ni = 1'b0;
    #3;
    total++; if (we_a_o !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", we_a_o); end
    total++; if (waddr_a_o !== 5'd0 || wdata_a_o !== 32'd0) begin bad++; $display("FAIL reset_wbus got=%0d/%h want=0/0", waddr_a_o, wdata_a_o); end
    total++; if (pending_a_o !== 1'b0 || pending_b_o !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b%b want=00", pending_a_o, pending_b_o); end
    total++; if (lsu_ready_o !== 1'b1 || ex_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b%b want=11", lsu_ready_o, ex_ready_o); end
    total++; if (we_a_e !== 1'b0) begin bad++; $display("FAIL reset_we_e got=%b want=0", we_a_e); end
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    ex_valid_i = 1'b1; ex_waddr_i = 5'd5; ex_wdata_i = 32'hDEADBEEF; raddr_a_i = 5'd5;
    #1;
    total++; if (ex_ready_o !== 1'b1 || pending_a_o !== 1'b0) begin bad++; $display("FAIL single_pre got rdy=%b pend=%b want 1 0", ex_ready_o, pending_a_o); end
    tick(); idle();
    total++; if (we_a_o !== 1'b1 || waddr_a_o !== 5'd5 || wdata_a_o !== 32'hDEADBEEF) begin
      bad++; $display("FAIL single_write got we=%b a=%0d d=%h want 1 5 deadbeef", we_a_o, waddr_a_o, wdata_a_o); end
    total++; if (pending_a_o !== 1'b1) begin bad++; $display("FAIL single_pending1 got=%b want=1", pending_a_o); end
    tick();
    total++; if (we_a_o !== 1'b0 || pending_a_o !== 1'b0) begin bad++; $display("FAIL single_after got we=%b pend=%b want 0 0", we_a_o, pending_a_o); end
  endtask

  task automatic test_dual_push();
    lsu_valid_i = 1'b1; lsu_waddr_i = 5'd3; lsu_wdata_i = 32'h11;
    ex_valid_i  = 1'b1; ex_waddr_i  = 5'd3; ex_wdata_i  = 32'h22;
    #1;
    total++; if (lsu_ready_o !== 1'b1 || ex_ready_o !== 1'b1) begin bad++; $display("FAIL dual_ready got=%b%b want=11", lsu_ready_o, ex_ready_o); end
    tick(); idle();
    total++; if (we_a_o !== 1'b1 || waddr_a_o !== 5'd3 || wdata_a_o !== 32'h11) begin
      bad++; $display("FAIL dual_first got we=%b a=%0d d=%h want 1 3 11", we_a_o, waddr_a_o, wdata_a_o); end
    tick();
    total++; if (we_a_o !== 1'b1 || waddr_a_o !== 5'd3 || wdata_a_o !== 32'h22) begin
      bad++; $display("FAIL dual_second got we=%b a=%0d d=%h want 1 3 22", we_a_o, waddr_a_o, wdata_a_o); end
    tick();
    total++; if (we_a_o !== 1'b0) begin bad++; $display("FAIL dual_drain got we=%b want=0", we_a_o); end
  endtask

  task automatic test_back_pressure();
    lsu_valid_i = 1'b1; lsu_waddr_i = 5'd1; lsu_wdata_i = 32'hA1;
    ex_valid_i  = 1'b1; ex_waddr_i  = 5'd2; ex_wdata_i  = 32'hA2;
    tick();
    lsu_waddr_i = 5'd4; lsu_wdata_i = 32'h44;
    ex_waddr_i  = 5'd6; ex_wdata_i  = 32'h66;
    #1;
    total++; if (lsu_ready_o !== 1'b1 || ex_ready_o !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b%b want=10", lsu_ready_o, ex_ready_o); end
    total++; if (waddr_a_o !== 5'd1) begin bad++; $display("FAIL bp_head1 got=%0d want=1", waddr_a_o); end
    tick();
    lsu_valid_i = 1'b0;
    #1;
    total++; if (ex_ready_o !== 1'b1 || waddr_a_o !== 5'd2) begin bad++; $display("FAIL bp_retry got rdy=%b a=%0d want 1 2", ex_ready_o, waddr_a_o); end
    tick(); idle();
    total++; if (waddr_a_o !== 5'd4 || wdata_a_o !== 32'h44) begin bad++; $display("FAIL bp_head3 got %0d/%h want 4/44", waddr_a_o, wdata_a_o); end
    tick();
    total++; if (we_a_o !== 1'b1 || waddr_a_o !== 5'd6 || wdata_a_o !== 32'h66) begin bad++; $display("FAIL bp_head4 got %b %0d/%h want 1 6/66", we_a_o, waddr_a_o, wdata_a_o); end
    tick();
    total++; if (we_a_o !== 1'b0) begin bad++; $display("FAIL bp_drain got we=%b want=0", we_a_o); end
  endtask

  task automatic test_x0_filter();
    ex_valid_i = 1'b1; ex_waddr_i = 5'd0; ex_wdata_i = 32'hFFFF_FFFF; raddr_a_i = 5'd0;
    #1;
    total++; if (ex_ready_o !== 1'b1) begin bad++; $display("FAIL x0_ready got=%b want=1", ex_ready_o); end
    tick(); idle();
    total++; if (we_a_o !== 1'b0 || pending_a_o !== 1'b0) begin bad++; $display("FAIL x0_dropped got we=%b pend=%b want 0 0", we_a_o, pending_a_o); end
    tick();
    total++; if (we_a_o !== 1'b0) begin bad++; $display("FAIL x0_later got we=%b want=0", we_a_o); end
  endtask

  task automatic test_reset_mid();
    lsu_valid_i = 1'b1; lsu_waddr_i = 5'd7; lsu_wdata_i = 32'h1;
    ex_valid_i  = 1'b1; ex_waddr_i  = 5'd8; ex_wdata_i  = 32'h2;
    raddr_a_i = 5'd8;
    tick(); idle();
    total++; if (we_a_o !== 1'b1 || pending_a_o !== 1'b1) begin bad++; $display("FAIL rstmid_pre got we=%b pend=%b want 1 1", we_a_o, pending_a_o); end
    rst_ni = 1'b0;
    #1;
    total++; if (we_a_o !== 1'b0 || waddr_a_o !== 5'd0 || pending_a_o !== 1'b0) begin
      bad++; $display("FAIL rstmid_async got we=%b a=%0d pend=%b want 0 0 0", we_a_o, waddr_a_o, pending_a_o); end
    total++; if (lsu_ready_o !== 1'b1 || ex_ready_o !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b%b want=11", lsu_ready_o, ex_ready_o); end
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (we_a_o !== 1'b0) begin bad++; $display("FAIL rstmid_post%0d got we=%b want=0", i, we_a_o); end
    end
  endtask

  task automatic test_rv32e();
    lsu_valid_i = 1'b1; lsu_waddr_i = 5'd17; lsu_wdata_i = 32'h1717; raddr_a_i = 5'd17;
    #1;
    total++; if (lsu_ready_e !== 1'b1) begin bad++; $display("FAIL e_ready got=%b want=1", lsu_ready_e); end
    tick(); idle();
    total++; if (we_a_e !== 1'b0 || pending_a_e !== 1'b0) begin bad++; $display("FAIL e_dropped got we=%b pend=%b want 0 0", we_a_e, pending_a_e); end
    total++; if (we_a_o !== 1'b1 || waddr_a_o !== 5'd17) begin bad++; $display("FAIL e_rv32i_kept got we=%b a=%0d want 1 17", we_a_o, waddr_a_o); end
    tick();
    total++; if (we_a_e !== 1'b0) begin bad++; $display("FAIL e_later got we=%b want=0", we_a_e); end
  endtask

  task automatic test_random();
    ent_t q[$];
    int   free;
    bit   lsu_rdy, ex_rdy, pa, pb;
    logic [4:0]  exp_a;
    logic [31:0] exp_d;
    q = {};
    for (int n = 0; n < 400; n++) begin
      lsu_valid_i = ($urandom_range(0, 3) != 0);
      ex_valid_i  = ($urandom_range(0, 3) != 0);
      lsu_waddr_i = 5'($urandom_range(0, 7));
      ex_waddr_i  = 5'($urandom_range(0, 7));
      lsu_wdata_i = $urandom;
      ex_wdata_i  = $urandom;
      raddr_a_i   = 5'($urandom_range(0, 7));
      raddr_b_i   = 5'($urandom_range(0, 7));
      #1;
      free    = 2 - q.size() + ((q.size() > 0) ? 1 : 0);
      lsu_rdy = (free >= 1);
      ex_rdy  = (free >= 1 + ((lsu_valid_i && lsu_waddr_i != 0) ? 1 : 0));
      pa = 1'b0; pb = 1'b0;
      foreach (q[i]) begin
        if (raddr_a_i != 0 && q[i].a == raddr_a_i) pa = 1'b1;
        if (raddr_b_i != 0 && q[i].a == raddr_b_i) pb = 1'b1;
      end
      exp_a = (q.size() > 0) ? q[0].a : 5'd0;
      exp_d = (q.size() > 0) ? q[0].d : 32'd0;
      total++; if (lsu_ready_o !== lsu_rdy || ex_ready_o !== ex_rdy) begin
        bad++; $display("FAIL rnd_ready n=%0d got=%b%b want=%b%b", n, lsu_ready_o, ex_ready_o, lsu_rdy, ex_rdy); end
      total++; if (we_a_o !== (q.size() > 0) || waddr_a_o !== exp_a || wdata_a_o !== exp_d) begin
        bad++; $display("FAIL rnd_write n=%0d got %b %0d/%h want %b %0d/%h", n, we_a_o, waddr_a_o, wdata_a_o, q.size() > 0, exp_a, exp_d); end
      total++; if (pending_a_o !== pa || pending_b_o !== pb) begin
        bad++; $display("FAIL rnd_pending n=%0d got=%b%b want=%b%b", n, pending_a_o, pending_b_o, pa, pb); end
      @(posedge clk_i);
      if (q.size() > 0) void'(q.pop_front());
      if (lsu_valid_i && lsu_rdy && lsu_waddr_i != 0) q.push_back('{lsu_waddr_i, lsu_wdata_i});
      if (ex_valid_i && ex_rdy && ex_waddr_i != 0) q.push_back('{ex_waddr_i, ex_wdata_i});
      #1;
    end
    idle();
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_dual_push();
    test_back_pressure();
    test_x0_filter();
    test_reset_mid();
    test_rv32e();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
